// File: rtl/tmr_serial_collector_if.sv
// Bus bundle for the TMR serial collector: serial input stream, control
// strobes, output word handshake and the fault-campaign status signals.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. A word is
// transferred on every rising clk edge where out_valid and out_ready are both
// high. Once out_valid is raised, it and data_out stay unchanged until that
// transfer happens; only reset may withdraw them. out_ready may toggle freely
// and does not combinationally affect out_valid.
interface tmr_serial_collector_if #(
   parameter int WIDTH     = 32,
   parameter int ERR_CNT_W = 8
);
   logic                 start;
   logic                 abort;
   logic                 bit_valid;
   logic                 serial_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     data_out;
   logic                 busy;
   logic                 overrun;
   logic                 tmr_error;
   logic [ERR_CNT_W-1:0] err_count;
   // Voted FSM state, exposed for debug and checker binding
   logic [1:0]           state_dbg;

   // Producer/consumer side (drives stimulus, consumes words)
   modport master (
      output start, abort, bit_valid, serial_in, out_ready,
      input  out_valid, data_out, busy, overrun, tmr_error, err_count, state_dbg
   );

   // Collector side
   modport slave (
      input  start, abort, bit_valid, serial_in, out_ready,
      output out_valid, data_out, busy, overrun, tmr_error, err_count, state_dbg
   );
endinterface

// File: rtl/tmr_serial_collector.sv
// TMR serial collector: reassembles WIDTH serial bits into a parallel word.
// FSM state, bit counter and shift register are kept in three copies which are
// majority-voted every cycle; the voted next value is written to all copies,
// so a single upset copy is scrubbed on the following edge. Any disagreement
// is reported as a one-cycle tmr_error pulse and counted in err_count.
module tmr_serial_collector #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,   // asynchronous, active low
   tmr_serial_collector_if.slave   bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_COLLECT = 2'b01;
   localparam logic [1:0] S_HOLD    = 2'b10;

   // Triplicated copies
   logic [1:0]       state_a_q, state_b_q, state_c_q;
   logic [CW-1:0]    cnt_a_q,   cnt_b_q,   cnt_c_q;
   logic [WIDTH-1:0] shift_a_q, shift_b_q, shift_c_q;

   // Voted values and common next values
   logic [1:0]       state_v, state_d;
   logic [CW-1:0]    cnt_v,   cnt_d;
   logic [WIDTH-1:0] shift_v, shift_d;

   // Single-copy output and status registers
   logic [WIDTH-1:0]     data_q, data_d;
   logic                 overrun_q, overrun_d;
   logic                 tmr_error_q, tmr_error_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 mismatch;

   // Bitwise 2-of-3 majority of every triplicated field
   always_comb begin
      state_v = (state_a_q & state_b_q) | (state_a_q & state_c_q) | (state_b_q & state_c_q);
      cnt_v   = (cnt_a_q   & cnt_b_q)   | (cnt_a_q   & cnt_c_q)   | (cnt_b_q   & cnt_c_q);
      shift_v = (shift_a_q & shift_b_q) | (shift_a_q & shift_c_q) | (shift_b_q & shift_c_q);
   end

   // Any copy bit that differs from the vote marks this cycle as a TMR error
   always_comb begin
      mismatch = (|(state_a_q ^ state_v)) | (|(state_b_q ^ state_v)) | (|(state_c_q ^ state_v))
               | (|(cnt_a_q   ^ cnt_v))   | (|(cnt_b_q   ^ cnt_v))   | (|(cnt_c_q   ^ cnt_v))
               | (|(shift_a_q ^ shift_v)) | (|(shift_b_q ^ shift_v)) | (|(shift_c_q ^ shift_v));
   end

   // Collector FSM, evaluated on voted values only
   always_comb begin
      state_d   = state_v;
      cnt_d     = cnt_v;
      shift_d   = shift_v;
      overrun_d = 1'b0;
      case (state_v)
         S_IDLE: begin
            // bit_valid is ignored until a word is armed
            if (bus.start) begin
               state_d = S_COLLECT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         S_COLLECT: begin
            // abort wins over a bit arriving in the same cycle; start is ignored
            if (bus.abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               shift_d = '0;
            end else if (bus.bit_valid) begin
               if (MSB_FIRST) begin
                  shift_d = {shift_v[WIDTH-2:0], bus.serial_in};
               end else begin
                  shift_d = {bus.serial_in, shift_v[WIDTH-1:1]};
               end
               if (cnt_v == CNT_LAST) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_v + CW'(1);
               end
            end
         end
         S_HOLD: begin
            // Word is frozen; incoming bits are dropped and reported, abort is ignored
            overrun_d = bus.bit_valid;
            if (bus.out_ready) begin
               if (bus.start) begin
                  state_d = S_COLLECT;
                  cnt_d   = '0;
                  shift_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            // Unreachable encoding after voting: recover to a clean idle
            state_d = S_IDLE;
            cnt_d   = '0;
            shift_d = '0;
         end
      endcase
   end

   // Output word follows the voted shift while held, keeps its last value otherwise
   always_comb begin
      data_d = data_q;
      if (state_v == S_HOLD) begin
         data_d = shift_v;
      end
   end

   // TMR error pulse and saturating error counter
   always_comb begin
      tmr_error_d = mismatch;
      err_cnt_d   = err_cnt_q;
      if (mismatch && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   // Triplicated registers: every copy reloads the same voted next value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_a_q <= S_IDLE;
         state_b_q <= S_IDLE;
         state_c_q <= S_IDLE;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
         cnt_c_q   <= '0;
         shift_a_q <= '0;
         shift_b_q <= '0;
         shift_c_q <= '0;
      end else begin
         state_a_q <= state_d;
         state_b_q <= state_d;
         state_c_q <= state_d;
         cnt_a_q   <= cnt_d;
         cnt_b_q   <= cnt_d;
         cnt_c_q   <= cnt_d;
         shift_a_q <= shift_d;
         shift_b_q <= shift_d;
         shift_c_q <= shift_d;
      end
   end

   // Single-copy output, pulse and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q      <= '0;
         overrun_q   <= 1'b0;
         tmr_error_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         data_q      <= data_d;
         overrun_q   <= overrun_d;
         tmr_error_q <= tmr_error_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.out_valid = (state_v == S_HOLD);
   assign bus.busy      = (state_v == S_COLLECT);
   assign bus.data_out  = data_d;
   assign bus.overrun   = overrun_q;
   assign bus.tmr_error = tmr_error_q;
   assign bus.err_count = err_cnt_q;
   assign bus.state_dbg = state_v;

endmodule

// File: tb/tb_tmr_serial_collector.sv
// Bench for tmr_serial_collector: an MSB-first and an LSB-first instance run
// side by side on the same stimulus, each checked every cycle against a
// word-level reference model and an expected-word queue.
module tb_tmr_serial_collector;

   localparam int W  = 32;
   localparam int EW = 8;

   localparam int M_IDLE    = 0;
   localparam int M_COLLECT = 1;
   localparam int M_HOLD    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int tests = 0;
   int fails = 0;

   // Reference model, one slot per instance (0: MSB first, 1: LSB first)
   int           m_mode[2];
   int           m_nb[2];
   logic [W-1:0] m_acc[2];
   logic [W-1:0] m_data[2];
   logic         m_ovr[2];
   logic         m_tmr[2];
   int           m_err[2];
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   // Clock
   always #5 clk = ~clk;

   tmr_serial_collector_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus0 ();
   tmr_serial_collector_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus1 ();

   tmr_serial_collector #(.WIDTH(W), .MSB_FIRST(1'b1), .ERR_CNT_W(EW)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   tmr_serial_collector #(.WIDTH(W), .MSB_FIRST(1'b0), .ERR_CNT_W(EW)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task model_reset();
      for (int m = 0; m < 2; m++) begin
         m_mode[m] = M_IDLE;
         m_nb[m]   = 0;
         m_acc[m]  = '0;
         m_data[m] = '0;
         m_ovr[m]  = 1'b0;
         m_tmr[m]  = 1'b0;
         m_err[m]  = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Word-level rules: bit number i of a word lands at W-1-i (MSB first) or i
   task model_step(input int m, input logic st, input logic ab, input logic bv,
                   input logic si, input logic rdy, input logic flt);
      logic [W-1:0] e;
      int pos;
      m_ovr[m] = 1'b0;
      case (m_mode[m])
         M_IDLE: begin
            if (st) begin
               m_mode[m] = M_COLLECT;
               m_nb[m]   = 0;
               m_acc[m]  = '0;
            end
         end
         M_COLLECT: begin
            if (ab) begin
               m_mode[m] = M_IDLE;
            end else if (bv) begin
               pos = (m == 0) ? (W - 1 - m_nb[m]) : m_nb[m];
               m_acc[m][pos] = si;
               m_nb[m] = m_nb[m] + 1;
               if (m_nb[m] == W) begin
                  m_mode[m] = M_HOLD;
                  m_data[m] = m_acc[m];
                  if (m == 0) exp_q0.push_back(m_acc[m]);
                  else        exp_q1.push_back(m_acc[m]);
               end
            end
         end
         default: begin
            m_ovr[m] = bv;
            if (rdy) begin
               if (m == 0) begin
                  if (exp_q0.size() > 0) e = exp_q0.pop_front();
                  else e = 'x;
                  chk("msb_sb_word", 64'(bus0.data_out), 64'(e));
               end else begin
                  if (exp_q1.size() > 0) e = exp_q1.pop_front();
                  else e = 'x;
                  chk("lsb_sb_word", 64'(bus1.data_out), 64'(e));
               end
               if (st) begin
                  m_mode[m] = M_COLLECT;
                  m_nb[m]   = 0;
                  m_acc[m]  = '0;
               end else begin
                  m_mode[m] = M_IDLE;
               end
            end
         end
      endcase
      m_tmr[m] = flt;
      if (flt && (m_err[m] != 255)) m_err[m] = m_err[m] + 1;
   endtask

   task check_outputs(input int m, input logic ov, input logic bsy, input logic ovr,
                      input logic te, input logic [W-1:0] d, input logic [EW-1:0] ec);
      string p;
      p = (m == 0) ? "msb" : "lsb";
      chk({p, "_out_valid"}, 64'(ov),  64'(m_mode[m] == M_HOLD));
      chk({p, "_busy"},      64'(bsy), 64'(m_mode[m] == M_COLLECT));
      chk({p, "_data_out"},  64'(d),   64'(m_data[m]));
      chk({p, "_overrun"},   64'(ovr), 64'(m_ovr[m]));
      chk({p, "_tmr_error"}, 64'(te),  64'(m_tmr[m]));
      chk({p, "_err_count"}, 64'(ec),  64'(m_err[m]));
   endtask

   task check_all();
      check_outputs(0, bus0.out_valid, bus0.busy, bus0.overrun, bus0.tmr_error,
                    bus0.data_out, bus0.err_count);
      check_outputs(1, bus1.out_valid, bus1.busy, bus1.overrun, bus1.tmr_error,
                    bus1.data_out, bus1.err_count);
   endtask

   // One clock cycle: drive both instances, optionally upset one copy of dut0
   // for the coming edge, step the model, then sample after the edge.
   // flt: 0 none, 1 shift copy B all ones, 2 state copy C forced to HOLD (2'b10)
   task cyc(input logic st, input logic ab, input logic bv, input logic si,
            input logic rdy, input int flt);
      bus0.start = st;  bus0.abort = ab;  bus0.bit_valid = bv;
      bus0.serial_in = si;  bus0.out_ready = rdy;
      bus1.start = st;  bus1.abort = ab;  bus1.bit_valid = bv;
      bus1.serial_in = si;  bus1.out_ready = rdy;
      if (flt == 1) begin
         force dut0.shift_b_q = {W{1'b1}};
         #1;
         release dut0.shift_b_q;
      end else if (flt == 2) begin
         force dut0.state_c_q = 2'b10;
         #1;
         release dut0.state_c_q;
      end
      model_step(0, st, ab, bv, si, rdy, flt != 0);
      model_step(1, st, ab, bv, si, rdy, 1'b0);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Bits lo..hi of w, MSB first on the wire, with random idle gaps
   task send_range(input logic [W-1:0] w, input int lo, input int hi, input int max_gap);
      int g;
      for (int i = lo; i <= hi; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
         cyc(1'b0, 1'b0, 1'b1, w[W-1-i], 1'b0, 0);
      end
   endtask

   task deliver(input int max_wait);
      int g;
      g = int'($urandom_range(0, max_wait));
      for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
   endtask

   initial begin
      logic [W-1:0] w;

      // Reset
      bus0.start = 1'b0;  bus0.abort = 1'b0;  bus0.bit_valid = 1'b0;
      bus0.serial_in = 1'b0;  bus0.out_ready = 1'b0;
      bus1.start = 1'b0;  bus1.abort = 1'b0;  bus1.bit_valid = 1'b0;
      bus1.serial_in = 1'b0;  bus1.out_ready = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Test 1: one word, no gaps; a stray start mid-word is ignored
      w = 32'hA5A5_0F0F;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) chk("t1_no_valid_before_last", 64'(bus0.out_valid), 64'd0);
         cyc(i == 5, 1'b0, 1'b1, w[W-1-i], 1'b0, 0);
      end
      chk("t1_out_valid", 64'(bus0.out_valid), 64'd1);
      chk("t1_data", 64'(bus0.data_out), 64'h0000_0000_A5A5_0F0F);
      chk("t1_busy", 64'(bus0.busy), 64'd0);
      chk("t1_tmr_error", 64'(bus0.tmr_error), 64'd0);

      // Test 2: backpressure with bits arriving in HOLD, abort ignored in HOLD
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 0);
         chk("t2_overrun", 64'(bus0.overrun), 64'd1);
         chk("t2_data_stable", 64'(bus0.data_out), 64'h0000_0000_A5A5_0F0F);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("t2_abort_ignored", 64'(bus0.out_valid), 64'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      chk("t2_idle_after_ready", 64'({bus0.out_valid, bus0.busy}), 64'd0);

      // Test 3: abort after 10 bits, then a full word of 1
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_range(32'hFFFF_FFFF, 0, 9, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      chk("t3_after_abort", 64'({bus0.out_valid, bus0.busy}), 64'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_range(32'h0000_0001, 0, W - 1, 0);
      chk("t3_data", 64'(bus0.data_out), 64'h0000_0000_0000_0001);
      deliver(2);

      // Test 4: one-cycle upset of shift copy B mid-word
      w = 32'h1234_5678;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_range(w, 0, 15, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      chk("t4_tmr_pulse", 64'(bus0.tmr_error), 64'd1);
      send_range(w, 16, W - 1, 0);
      chk("t4_data", 64'(bus0.data_out), 64'h0000_0000_1234_5678);
      chk("t4_err_count", 64'(bus0.err_count), 64'd1);
      deliver(1);

      // Test 5: repeated upsets of state copy C during COLLECT, counter saturates
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      chk("t5_err_sat", 64'(bus0.err_count), 64'd255);
      chk("t5_still_collect", 64'({bus0.out_valid, bus0.busy}), 64'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      // Test 6: first bit 1 then zeros; back-to-back restart from HOLD
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_range(32'h8000_0000, 0, W - 1, 0);
      chk("t6_lsb_first_data", 64'(bus1.data_out), 64'h0000_0000_0000_0001);
      chk("t6_msb_first_data", 64'(bus0.data_out), 64'h0000_0000_8000_0000);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      chk("t6_back_to_back_busy", 64'(bus1.busy), 64'd1);
      w = $urandom();
      send_range(w, 0, W - 1, 1);
      deliver(3);

      // Random words with random bit gaps and consumer delays
      for (int n = 0; n < 6; n++) begin
         w = $urandom();
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
         send_range(w, 0, W - 1, 2);
         deliver(4);
      end

      // Free-running random control traffic
      for (int n = 0; n < 500; n++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) == 0, 0);
      end

      // Reset mid-collection: partial word lost, everything back to reset values
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_range(32'hDEAD_BEEF, 0, 4, 0);
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("reset_idle_ignores_bits", 64'({bus0.busy, bus1.busy}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
